// File: rtl/mcs4_ram_host_pkg.sv
// mcs4_ram_host_pkg: bus phases, request opcodes, OPR codes, I/O OPA table and FSM states.
package mcs4_ram_host_pkg;
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SRC, S_IO, S_RESP} state_t;
  localparam logic [2:0] OP_WRM = 3'd0;
  localparam logic [2:0] OP_RDM = 3'd1;
  localparam logic [2:0] OP_WRN = 3'd2;
  localparam logic [2:0] OP_RDN = 3'd3;
  localparam logic [2:0] OP_SBM = 3'd4;
  localparam logic [2:0] OP_ADM = 3'd5;
  localparam logic [3:0] OPR_SRC = 4'h2;
  localparam logic [3:0] OPR_IO = 4'hE;

  function automatic logic [3:0] io_opa(input logic [2:0] op, input logic [1:0] n);
    return op == OP_WRN ? {2'b01, n} :
           op == OP_RDN ? {2'b11, n} :
           op == OP_SBM ? 4'h8 :
           op == OP_RDM ? 4'h9 :
           op == OP_ADM ? 4'hB : 4'h0;
  endfunction

  function automatic logic is_write(input logic [2:0] op);
    return op == OP_WRM || op == OP_WRN;
  endfunction
endpackage

// File: rtl/mcs4_bus_phase_gen.sv
// mcs4_bus_phase_gen: 8-clock MCS-4 phase counter with SYNC_N and a one-hot view of the next phase.
module mcs4_bus_phase_gen
  import mcs4_ram_host_pkg::*;
(
  input  logic       clk,
  input  logic       res_n,
  output logic       sync_n,
  output logic [7:0] nxt_oh
);
  phase_t ph, nxt;
  logic run;

  // The first clock after reset re-enters X3 so that cycle carries the SYNC_N pulse.
  assign nxt = run ? phase_t'(ph + 3'd1) : X3;
  assign nxt_oh = 8'd1 << nxt;

  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      ph <= X3;
      run <= 1'b0;
      sync_n <= 1'b1;
    end else begin
      ph <= nxt;
      run <= 1'b1;
      sync_n <= nxt != X3;
    end
endmodule

// File: rtl/mcs4_ram_host_seq.sv
// mcs4_ram_host_seq: bus-master sequencer issuing SRC + I/O slots to the MCS-4 RAM array.
// Define MCS4_RAM_HOST_SRC_CACHE_EN to skip the SRC slot when bank and address repeat.
module mcs4_ram_host_seq
  import mcs4_ram_host_pkg::*;
#(
  parameter int         NUM_BANKS = 8,
  parameter logic [3:0] SRC_OPA   = 4'h1
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_op,
  input  logic [2:0]           req_bank,
  input  logic [7:0]           req_addr,
  input  logic [1:0]           req_stidx,
  input  logic [3:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [3:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 sync_n,
  output logic [NUM_BANKS-1:0] cm_n,
  output logic [3:0]           data_o,
  output logic                 data_oe,
  input  logic [3:0]           data_i,
  input  logic                 data_i_oe
);
  logic [7:0] nxt_oh;
  state_t state, ns;
  logic [2:0] op_q, bank_q;
  logic [7:0] addr_q;
  logic [1:0] stidx_q;
  logic [3:0] wdata_q, opa, d_nxt;
  logic hs, legal, wr, hit, src, io, oe_nxt, cm_nxt, smp;

  mcs4_bus_phase_gen u_phase (
    .clk(clk),
    .res_n(res_n),
    .sync_n(sync_n),
    .nxt_oh(nxt_oh)
  );

  assign hs = req_valid && req_ready;
  assign legal = req_op <= OP_ADM;
  assign wr = is_write(op_q);
  assign opa = io_opa(op_q, stidx_q);
  assign smp = state == S_IO && nxt_oh[X3] && !wr;

`ifdef MCS4_RAM_HOST_SRC_CACHE_EN
  logic c_vld;
  logic [10:0] c_key;
  assign hit = c_vld && c_key == {bank_q, addr_q};
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      c_vld <= 1'b0;
      c_key <= '0;
    end else if (state == S_WAIT && ns == S_SRC) begin
      c_vld <= 1'b1;
      c_key <= {bank_q, addr_q};
    end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    ns = state;
    case (state)
      S_IDLE: if (hs) ns = legal ? S_WAIT : S_RESP;
      S_WAIT: if (nxt_oh[A1]) ns = hit ? S_IO : S_SRC;
      S_SRC:  if (nxt_oh[A1]) ns = S_IO;
      S_IO:   if (nxt_oh[A1]) ns = S_RESP;
      S_RESP: if (rsp_valid) ns = S_IDLE;
      default: ns = S_IDLE;
    endcase
  end

  // Bus outputs are registered, so they are derived from the state and phase of the coming cycle.
  assign src = ns == S_SRC;
  assign io = ns == S_IO;
  assign d_nxt = nxt_oh[M1] ? (src ? OPR_SRC : io ? OPR_IO : 4'h0) :
                 nxt_oh[M2] ? (src ? SRC_OPA : io ? opa : 4'h0) :
                 nxt_oh[X2] ? (src ? addr_q[7:4] : io && wr ? wdata_q : 4'h0) :
                 nxt_oh[X3] && src ? addr_q[3:0] : 4'h0;
  assign oe_nxt = !nxt_oh[X1] && (!(nxt_oh[X2] || nxt_oh[X3]) || src || io && wr && nxt_oh[X2]);
  assign cm_nxt = src && nxt_oh[X2] || io && nxt_oh[M2];

  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state <= S_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 4'h0;
      rsp_err <= 1'b0;
      cm_n <= '1;
      data_o <= 4'h0;
      data_oe <= 1'b0;
      op_q <= '0;
      bank_q <= '0;
      addr_q <= '0;
      stidx_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= ns;
      req_ready <= ns == S_IDLE;
      rsp_valid <= ns == S_RESP && nxt_oh[A1];
      cm_n <= cm_nxt ? ~(NUM_BANKS'(1) << bank_q) : '1;
      data_o <= d_nxt;
      data_oe <= oe_nxt;
      if (hs) begin
        op_q <= req_op;
        bank_q <= req_bank;
        addr_q <= req_addr;
        stidx_q <= req_stidx;
        wdata_q <= req_wdata;
        rsp_rdata <= 4'h0;
        rsp_err <= !legal;
      end
      if (smp) begin
        rsp_rdata <= data_i_oe ? data_i : 4'h0;
        rsp_err <= !data_i_oe;
      end
    end
endmodule

// File: tb/tb_mcs4_ram_host_seq.sv
// tb_mcs4_ram_host_seq: directed + random requests checked cycle by cycle against a slot-level model.
module tb_mcs4_ram_host_seq;
  logic clk = 1'b0, res_n = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [2:0] req_op = '0, req_bank = '0;
  logic [7:0] req_addr = '0;
  logic [1:0] req_stidx = '0;
  logic [3:0] req_wdata = '0;
  logic rsp_valid, rsp_err, sync_n, data_oe;
  logic [3:0] rsp_rdata, data_o;
  logic [7:0] cm_n;
  logic [3:0] data_i = '0;
  logic data_i_oe = 1'b0;
  int tests_run = 0, n_fail = 0, cyc = 0;
  logic [3:0] mem [2048];
  logic [3:0] st [512];
  bit cvalid = 1'b0;
  logic [10:0] ckey = '0;

  mcs4_ram_host_seq dut (
    .clk(clk), .res_n(res_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_bank(req_bank), .req_addr(req_addr), .req_stidx(req_stidx),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sync_n(sync_n), .cm_n(cm_n), .data_o(data_o), .data_oe(data_oe),
    .data_i(data_i), .data_i_oe(data_i_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= res_n ? cyc + 1 : 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests_run++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Cycle k after reset release (k=1 is the first) sits in phase X3 for k=1, A1 for k=2, ...
  function automatic int phof(input int k);
    return (k + 6) % 8;
  endfunction

  function automatic logic [3:0] opa(input logic [2:0] op, input logic [1:0] n);
    case (op)
      3'd0: return 4'h0;
      3'd1: return 4'h9;
      3'd2: return 4'(4 + n);
      3'd3: return 4'(12 + n);
      3'd4: return 4'h8;
      default: return 4'hB;
    endcase
  endfunction

  // kind: 0 = NOP slot, 1 = SRC slot, 2 = I/O slot
  function automatic logic [15:0] exp_vec(input int kind, input int ph, input logic rv, input logic rdy,
                                          input logic [2:0] op, input logic [2:0] bank,
                                          input logic [7:0] addr, input logic [1:0] n, input logic [3:0] wd);
    logic [3:0] d;
    logic oe;
    logic [7:0] cm, sel;
    d = 4'h0;
    oe = ph <= 4;
    cm = 8'hFF;
    sel = ~(8'd1 << bank);
    if (kind == 1) begin
      if (ph == 3) d = 4'h2;
      if (ph == 4) d = 4'h1;
      if (ph == 6) begin d = addr[7:4]; oe = 1'b1; cm = sel; end
      if (ph == 7) begin d = addr[3:0]; oe = 1'b1; end
    end else if (kind == 2) begin
      if (ph == 3) d = 4'hE;
      if (ph == 4) begin d = opa(op, n); cm = sel; end
      if (ph == 6 && (op == 3'd0 || op == 3'd2)) begin d = wd; oe = 1'b1; end
    end
    return {ph != 7, rv, rdy, cm, oe, d};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", {sync_n, rsp_valid, req_ready, cm_n, data_oe, data_o},
          exp_vec(0, phof(cyc), 1'b0, 1'b1, 3'd0, 3'd0, 8'h0, 2'd0, 4'h0));
    end
  endtask

  task automatic reset_check(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_rdata, rsp_err, sync_n, cm_n, data_o, data_oe},
        {1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hFF, 4'h0, 1'b0});
  endtask

  task automatic xact(input logic [2:0] op, input logic [2:0] bank, input logic [7:0] addr,
                      input logic [1:0] n, input logic [3:0] wd, input bit ram_oe,
                      input bit hold, input bit abort);
    int h, first, src, io, resp, w, kind;
    bit legal, hit, rd;
    logic [3:0] val, exp_rd;
    bit exp_err;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_wait", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_bank = bank; req_addr = addr; req_stidx = n; req_wdata = wd;
    @(negedge clk);
    h = cyc;
    req_valid = 1'b0;
    legal = op <= 3'd5;
    rd = legal && op != 3'd0 && op != 3'd2;
    hit = 1'b0;
`ifdef MCS4_RAM_HOST_SRC_CACHE_EN
    hit = legal && cvalid && ckey == {bank, addr};
`endif
    first = legal ? h + 1 : h;
    while (phof(first) != 0) first++;
    src = -100;
    io = -100;
    if (!legal) resp = first;
    else begin
      if (hit) io = first;
      else begin src = first; io = first + 8; end
      resp = io + 8;
    end
    val = op == 3'd3 ? st[{bank, addr[7:4], n}] : mem[{bank, addr}];
    exp_rd = rd && ram_oe ? val : 4'h0;
    exp_err = !legal || (rd && !ram_oe);
    for (int k = h; k <= resp + 1; k++) begin
      if (k > h) @(negedge clk);
      kind = (k >= src && k < src + 8) ? 1 : (k >= io && k < io + 8) ? 2 : 0;
      chk("bus", {sync_n, rsp_valid, req_ready, cm_n, data_oe, data_o},
          exp_vec(kind, phof(k), k == resp, k == resp + 1, op, bank, addr, n, wd));
      if (k == resp) chk("rsp", {rsp_rdata, rsp_err}, {exp_rd, exp_err});
      if (rd && k == io + 6) begin data_i = ram_oe ? val : 4'($urandom); data_i_oe = ram_oe; end
      if (k == io + 7) begin data_i = 4'h0; data_i_oe = 1'b0; end
      if (hold) begin
        req_valid = k < resp;
        if (k == h) begin
          req_op = 3'($urandom); req_bank = 3'($urandom); req_addr = 8'($urandom);
          req_stidx = 2'($urandom); req_wdata = 4'($urandom);
        end
      end
      if (abort && k == io + 2) begin
        res_n = 1'b0;
        req_valid = 1'b0;
        #1;
        reset_check("abort_reset");
        cvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        res_n = 1'b1;
        break;
      end
    end
    if (!abort && legal) begin
      if (op == 3'd0) mem[{bank, addr}] = wd;
      if (op == 3'd2) st[{bank, addr[7:4], n}] = wd;
      cvalid = 1'b1;
      ckey = {bank, addr};
    end
  endtask

  initial begin
    logic [2:0] op, bank;
    logic [7:0] addr;
    for (int i = 0; i < 2048; i++) mem[i] = 4'h0;
    for (int i = 0; i < 512; i++) st[i] = 4'h0;
    @(negedge clk);
    reset_check("reset");
    res_n = 1'b1;
    idle(24);
    xact(3'd0, 3'd2, 8'h5A, 2'd0, 4'h7, 1'b1, 1'b0, 1'b0);
    xact(3'd1, 3'd2, 8'h5A, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    xact(3'd1, 3'd2, 8'h9A, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    xact(3'd2, 3'd5, 8'hC0, 2'd3, 4'hB, 1'b1, 1'b0, 1'b0);
    xact(3'd3, 3'd5, 8'hC0, 2'd3, 4'h0, 1'b1, 1'b1, 1'b0);
    xact(3'd4, 3'd2, 8'h5A, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    xact(3'd5, 3'd2, 8'h5A, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0);
    xact(3'd6, 3'd3, 8'h11, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    xact(3'd7, 3'd4, 8'h22, 2'd1, 4'h5, 1'b1, 1'b1, 1'b0);
    xact(3'd1, 3'd2, 8'h5A, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    idle(3);
    xact(3'd1, 3'd1, 8'h33, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1);
    idle(20);
    xact(3'd0, 3'd1, 8'h33, 2'd0, 4'h9, 1'b1, 1'b0, 1'b0);
    xact(3'd1, 3'd1, 8'h33, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    op = 3'd0;
    bank = 3'd0;
    addr = 8'h0;
    for (int i = 0; i < 48; i++) begin
      op = $urandom_range(0, 11) == 0 ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      if ($urandom_range(0, 2) != 0) begin
        bank = 3'($urandom_range(0, 7));
        addr = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
      end
      idle($urandom_range(0, 6));
      xact(op, bank, addr, 2'($urandom), 4'($urandom), $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0, 1'b0);
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mcs4_ram_host_seq.md
Name: mcs4_ram_host_seq

Overview:
Bus-master sequencer that drives the MCS-4 RAM system (8 banks x 4 i4002 chips) in place of a 4004 CPU. It is used for testbench preload and readback, and for FPGA debug access.
Each accepted request runs as two 8-clock instruction slots. The first is an SRC slot that loads the chip/register/character address. The second is an I/O slot that carries WRM, RDM, SBM, ADM, WRn or RDn. Outside transactions the block emits continuous NOP slots so the RAM chips stay synchronised.

Parameters:
NUM_BANKS, 8, number of CM_N lines and width of the REQ_BANK decode (REQ_BANK is 3 bits, so at most 8).
SRC_OPA, 4'h1, OPA nibble driven at M2 of an SRC slot.

Ports:
CLK  in  1  clock
RES_N  in  1  reset, asynchronous, active-low
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY at a rising edge
REQ_OP  in  3  0=WRM, 1=RDM, 2=WRn, 3=RDn, 4=SBM, 5=ADM, 6/7=illegal
REQ_BANK  in  3  CM_N line to assert
REQ_ADDR  in  8  SRC address: [7:6] chip, [5:4] register, [3:0] character
REQ_STIDX  in  2  status-character index n for WRn/RDn
REQ_WDATA  in  4  write nibble
RSP_VALID  out  1  one-cycle completion pulse
RSP_RDATA  out  4  read nibble (0 for write ops)
RSP_ERR  out  1  illegal op, or no RAM drove the bus on a read
SYNC_N  out  1  to RAM SYNC_N
CM_N  out  NUM_BANKS  to RAM CM_N
DATA_O  out  4  to RAM DATA_I
DATA_OE  out  1  host drives the bus
DATA_I  in  4  from RAM DATA_O
DATA_I_OE  in  1  from RAM DATA_OE

Behaviour:
- Outputs are registered. Reset values: REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, SYNC_N=1, CM_N=all ones, DATA_O=0, DATA_OE=0. Phase resets to X3.
- Phase counter runs A1,A2,A3,M1,M2,X1,X2,X3 and wraps every 8 clocks.
  - SYNC_N=0 only in the X3 cycle, so the RAM enters A1 on the next clock.
  - The first cycle after reset release is X3 with SYNC_N=0.
- FSM states IDLE, WAIT, SRC, IO, RESP.
  - IDLE: REQ_READY=1. A handshake latches all request fields and moves to WAIT.
  - An illegal op goes straight to RESP with RSP_ERR=1 and issues no bus slot.
  - WAIT: go to SRC at the next A1.
  - SRC lasts 8 clocks, then IO lasts 8 clocks.
  - RESP: RSP_VALID=1 for the single cycle that is the next slot's A1; then return to IDLE, with REQ_READY high again the following cycle.
- Latency: RSP_VALID appears exactly 16 clocks after the first SRC A1 cycle.
- DATA_O per phase:
  - A1-A3: 0.
  - M1: 4'h2 for SRC, 4'hE for IO, 0 for NOP.
  - M2: SRC_OPA for SRC, the I/O OPA for IO, 0 for NOP.
- I/O OPA values: WRM=0, WRn=4+n, SBM=8, RDM=9, ADM=B, RDn=C+n.
- SRC slot: X2 drives REQ_ADDR[7:4] with CM_N[REQ_BANK]=0 during X2 only. X3 drives REQ_ADDR[3:0].
- IO slot: CM_N[REQ_BANK]=0 during M2 only. For writes, X2 drives REQ_WDATA.
- DATA_OE:
  - 1 in A1-M2 of every slot.
  - 1 in X2-X3 of SRC slots.
  - 1 in X2 of write IO slots.
  - 0 in every other cycle.
- Read ops (RDM, SBM, ADM, RDn): DATA_I is sampled at the edge ending IO X2.
  - If DATA_I_OE=0 at that edge: RSP_RDATA=0 and RSP_ERR=1.
- REQ_VALID held during a non-IDLE state is ignored (REQ_READY=0).
- Asserting RES_N mid-transaction aborts it: outputs return to reset values, no RSP_VALID is produced, and the latched request is discarded.
- CM_N is never low in two banks at once, and never low in NOP slots.

Optional Feature:
MCS4_RAM_HOST_SRC_CACHE_EN
- Defined: the block keeps the last issued {bank, addr} plus a valid bit, cleared by reset.
  - A request matching the valid cached value skips the SRC slot: WAIT goes to IO, and RSP_VALID comes 8 clocks after the IO A1.
  - Illegal ops do not update the cache.
- Undefined: every request issues an SRC slot.

Decomposition:
- Package mcs4_ram_host_pkg holds:
  - phase constants A1..X3;
  - REQ_OP encodings;
  - OPR constants (SRC=2, IO=E);
  - the I/O OPA table;
  - the FSM state enum.
- Sub-module mcs4_bus_phase_gen holds the phase counter, SYNC_N generation and a one-hot phase output.

Test Plan:
- Reset release, no requests -> SYNC_N low once every 8 clocks starting in the first cycle; CM_N=FF; DATA_OE=0 in X1-X3.
- WRM, bank 2, addr 8'h5A, wdata 4'h7 -> SRC slot: X2 DATA_O=5 with CM_N=FB; X3 DATA_O=A. IO slot: M1 DATA_O=E, M2 DATA_O=0 with CM_N=FB, X2 DATA_O=7. RSP_VALID 16 clocks after SRC A1 with RSP_ERR=0.
- RDM bank 2 addr 8'h5A after the above -> RSP_RDATA=7, RSP_ERR=0. Same access at addr 8'h9A (chip 2, unwritten) -> RSP_RDATA=0 after reset clear.
- WR3 addr 8'hC0 wdata B, then RD3 same addr -> IO OPA 7 then F; RSP_RDATA=B.
- REQ_OP=6 -> RSP_ERR=1, no CM_N assertion, RSP_VALID at the next A1. A read with DATA_I_OE forced 0 -> RSP_ERR=1.
- RES_N pulsed during an IO slot -> no RSP_VALID; the next request completes normally. With the SRC cache enabled, a repeated address gives 8-clock latency and no SRC slot.
